pipe_hazard_ctrl: RTL

Central pipeline sequencer for the 5-stage ARM64 core. Drives the write-enable and flush (bubble) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Handles four cases:
- load-use hazards
- taken branches resolved in EX
- multi-cycle multiply occupancy of EX
- data-memory wait states

Keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline sequencer: stall/flush control and perf counters
// Combinational per-register enables from the current hazards; MUL occupancy tracked by a small FSM.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic             ex_mul_start,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             ex_mem_flush,
  output logic             mem_wb_we,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mul_busy
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  localparam int CB     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam bit MUL_EN = (MUL_LAT > 1);

  state_t        state, state_nxt;
  logic [CB-1:0] cnt, cnt_nxt;
  logic          load_use;
  logic          flush_inc;

  // XZR (r31) is never a real destination, so it cannot create a hazard.
  always_comb begin
    load_use = ex_memread && (ex_rd != 5'd31) &&
               ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));
  end

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_we    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_we    = 1'b1;
    flush_inc    = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    if (!resetl) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (mem_busy) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (state == RUN) begin
      if (ex_br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (ex_mul_start && MUL_EN) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_flush = 1'b1;
        state_nxt    = MUL_WAIT;
        cnt_nxt      = CB'(MUL_LAT - 1);
      end else if (load_use) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end else begin
      // Last MUL_WAIT cycle lets the product advance into EX/MEM.
      if (cnt > CB'(1)) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_flush = 1'b1;
        cnt_nxt      = cnt - CB'(1);
      end else begin
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
    end
  end

  assign mul_busy = resetl && (state == MUL_WAIT);

  always_ff @(posedge clk) begin
    if (!resetl) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_we && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_events != {CNT_W{1'b1}}))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule
